split_slave_mem: RTL and testbench
==================================

SPLIT_SLAVE_MEM -- requirements
Module: split_slave_mem

Interface
REQ-001 Parameter ADDR_LEN, 12, serial address width in bits.
REQ-002 Parameter DATA_LEN, 8, data word width in bits.
REQ-003 Parameter BURST_LEN, 12, serial burst-count width; ADDR_LEN >= BURST_LEN.
REQ-004 Parameter MEM_DEPTH, 4096, words of storage; power of two, at most 2^ADDR_LEN.
REQ-005 Parameter SPLIT_THRESHOLD, 8, a read whose s_slave_delay exceeds this value is split.
REQ-006 The clock and reset ports SHALL be exactly as follows: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  single bus clock; all logic on its rising edge.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 s_slave_delay  in  6  wait cycles inserted before each write commit and each read fetch.
REQ-010 s_read_en / s_write_en  in  1  transaction type; sampled on the first address bit.
REQ-011 s_master_valid  in  1  master drives a valid bit on s_rx_address/s_rx_burst/s_rx_data.
REQ-012 s_master_ready  in  1  master accepts a bit on s_tx_data.
REQ-013 s_rx_address / s_rx_burst / s_rx_data  in  1 each  serial inputs, LSB first.
REQ-014 s_slave_ready  out  1  slave accepts inbound bits.
REQ-015 s_slave_valid  out  1  s_tx_data holds a valid bit.
REQ-016 s_tx_data  out  1  serial read data, LSB first.
REQ-017 s_split_en  out  1  slave has split the bus and is preparing read data.

Function
REQ-018 An inbound bit SHALL transfer only on a cycle with s_master_valid=1 and s_slave_ready=1; an outbound bit only with s_slave_valid=1 and s_master_ready=1.
REQ-019 States SHALL be IDLE, ADDR, WDATA, WAIT, RFETCH, SPLIT, RESUME, RDATA.
REQ-020 IDLE: s_slave_ready=1; the first accepted bit with read_en xor write_en = 1 SHALL enter ADDR and latch the type; bits with both or neither enable set SHALL be ignored.
REQ-021 ADDR: address bits SHALL shift in for ADDR_LEN transfers (the IDLE bit counts as bit 0); burst bits SHALL shift in concurrently over the first BURST_LEN transfers.
REQ-022 A burst value of 0 SHALL be treated as 1 beat; beat address = base + beat index, modulo MEM_DEPTH; upper address bits above log2(MEM_DEPTH) SHALL be ignored.
REQ-023 Write: WDATA SHALL shift DATA_LEN bits per beat, then enter WAIT for s_slave_delay cycles with s_slave_ready=0, commit the word, and return to WDATA, or to IDLE after the last beat.
REQ-024 Read with s_slave_delay <= SPLIT_THRESHOLD: WAIT for s_slave_delay cycles, then RFETCH (1 cycle, synchronous memory read), then RDATA.
REQ-025 Read with s_slave_delay > SPLIT_THRESHOLD: after ADDR the block SHALL enter SPLIT with s_split_en=1 and s_slave_ready=0; it SHALL count s_slave_delay cycles, fetch the first word, clear s_split_en, and enter RESUME.
REQ-026 RESUME: s_slave_ready=1; the first cycle with s_master_valid=1 SHALL enter RDATA; no bits are consumed.
REQ-027 RDATA: s_slave_valid=1; DATA_LEN bits per beat; s_master_ready=0 SHALL hold the current bit stable; after each beat, further beats use WAIT then RFETCH without re-splitting; after the last beat, return to IDLE.
REQ-028 s_slave_delay=0 SHALL give zero-cycle WAIT; minimum read latency is 1 cycle from the last address bit to the first valid s_tx_data bit.
REQ-029 s_master_valid deasserting mid-field SHALL stall the shift without losing the bit count.
REQ-030 Outputs SHALL be registered; no output may combinationally depend on inputs.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, s_slave_ready=1, s_slave_valid=0, s_tx_data=0, s_split_en=0, and clear all counters and shift registers.
REQ-032 Memory contents SHALL NOT be cleared by reset; reset mid-write SHALL abort without committing the partial word.

Verification
REQ-033 Single write then read, delay 0: write 0xA5 to address 0x010, burst 1; read 0x010 -> s_tx_data serialises 1,0,1,0,0,1,0,1 (LSB first).
REQ-034 Burst wrap: write burst 3 at address MEM_DEPTH-1 with data 0x11, 0x22, 0x33 -> reads of addresses 4095, 0, 1 return 0x11, 0x22, 0x33.
REQ-035 Split read: delay 20 -> s_split_en=1 for 20+1 cycles, then 0; data is withheld until s_master_valid=1; correct word returned.
REQ-036 Backpressure: drop s_master_ready for 5 cycles mid-read -> s_tx_data is held and no bit is lost or duplicated.
REQ-037 Reset mid-write after 4 data bits -> all outputs at reset values; the target word is unchanged on a later read.
REQ-038 Illegal type: first bit with read_en=write_en=1 -> stays in IDLE, no memory change.

Source files
------------

// File: rtl/split_slave_mem.sv
// Serial-bus slave memory. Address, burst and data fields arrive one bit per handshake, LSB first.
// Long-latency reads split the bus and resume once the master signals it is back.
module split_slave_mem #(
    parameter int ADDR_LEN        = 12,
    parameter int DATA_LEN        = 8,
    parameter int BURST_LEN       = 12,
    parameter int MEM_DEPTH       = 4096,
    parameter int SPLIT_THRESHOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] s_slave_delay,
    input  logic       s_read_en,
    input  logic       s_write_en,
    input  logic       s_master_valid,
    input  logic       s_master_ready,
    input  logic       s_rx_address,
    input  logic       s_rx_burst,
    input  logic       s_rx_data,
    output logic       s_slave_ready,
    output logic       s_slave_valid,
    output logic       s_tx_data,
    output logic       s_split_en
);

    localparam int MA        = $clog2(MEM_DEPTH);
    localparam int FIELD_MAX = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int CNT_W     = $clog2(FIELD_MAX + 1);
    localparam logic [5:0] SPLIT_TH = 6'(SPLIT_THRESHOLD);

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, WAIT, RFETCH, SPLIT, RESUME, RDATA
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_is_read;
    logic [ADDR_LEN-1:0]   r_addr_sr;
    logic [BURST_LEN-1:0]  r_burst_sr;
    logic [BURST_LEN-1:0]  r_beats;
    logic [BURST_LEN-1:0]  r_beat_idx;
    logic [MA-1:0]         r_base;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [5:0]            r_wait_cnt;
    logic [5:0]            r_delay;
    logic [DATA_LEN-1:0]   r_wdata_sr;
    logic [DATA_LEN-1:0]   r_tx_sr;
    logic                  r_slave_ready;
    logic                  r_slave_valid;
    logic                  r_split_en;
    logic [DATA_LEN-1:0]   r_mem [MEM_DEPTH];

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic [ADDR_LEN-1:0]   w_addr_full;
    logic [BURST_LEN-1:0]  w_burst_full;
    logic [DATA_LEN-1:0]   w_wdata_full;
    logic                  w_addr_last;
    logic                  w_data_last;
    logic                  w_last_beat;
    logic                  w_wait_done;
    logic                  w_split_done;
    logic [ADDR_LEN-1:0]   w_addr_sum;
    logic [MA-1:0]         w_beat_addr;
    logic                  w_mem_we;
    logic [DATA_LEN-1:0]   w_mem_wdata;

    assign w_in_fire    = s_master_valid & r_slave_ready;
    assign w_out_fire   = r_slave_valid & s_master_ready;
    assign w_addr_full  = {s_rx_address, r_addr_sr[ADDR_LEN-1:1]};
    // Burst bits ride along with the first BURST_LEN address bits only.
    assign w_burst_full = (r_bit_cnt < CNT_W'(BURST_LEN)) ? {s_rx_burst, r_burst_sr[BURST_LEN-1:1]}
                                                          : r_burst_sr;
    assign w_wdata_full = {s_rx_data, r_wdata_sr[DATA_LEN-1:1]};
    assign w_addr_last  = (r_bit_cnt == CNT_W'(ADDR_LEN - 1));
    assign w_data_last  = (r_bit_cnt == CNT_W'(DATA_LEN - 1));
    assign w_last_beat  = (r_beat_idx == r_beats - BURST_LEN'(1));
    assign w_wait_done  = (r_wait_cnt == r_delay - 6'd1);
    assign w_split_done = (r_wait_cnt == r_delay);
    assign w_addr_sum   = ADDR_LEN'(r_base) + ADDR_LEN'(r_beat_idx);
    assign w_beat_addr  = w_addr_sum[MA-1:0];

    assign s_slave_ready = r_slave_ready;
    assign s_slave_valid = r_slave_valid;
    assign s_split_en    = r_split_en;
    assign s_tx_data     = r_tx_sr[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_mem_we    = 1'b0;
        w_mem_wdata = r_wdata_sr;
        case (r_state)
            IDLE:   if (w_in_fire && (s_read_en ^ s_write_en)) w_next = ADDR;
            ADDR: begin
                if (w_in_fire && w_addr_last) begin
                    if (!r_is_read)                    w_next = WDATA;
                    else if (s_slave_delay > SPLIT_TH) w_next = SPLIT;
                    else if (s_slave_delay == 6'd0)    w_next = RFETCH;
                    else                               w_next = WAIT;
                end
            end
            WDATA: begin
                if (w_in_fire && w_data_last) begin
                    if (r_delay == 6'd0) begin
                        w_mem_we    = 1'b1;
                        w_mem_wdata = w_wdata_full;
                        w_next      = w_last_beat ? IDLE : WDATA;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (w_wait_done) begin
                    if (r_is_read) begin
                        w_next = RFETCH;
                    end else begin
                        w_mem_we = 1'b1;
                        w_next   = w_last_beat ? IDLE : WDATA;
                    end
                end
            end
            RFETCH: w_next = RDATA;
            SPLIT:  if (w_split_done) w_next = RESUME;
            RESUME: if (s_master_valid) w_next = RDATA;
            RDATA: begin
                if (w_out_fire && w_data_last) begin
                    if (w_last_beat)            w_next = IDLE;
                    else if (r_delay == 6'd0)   w_next = RFETCH;
                    else                        w_next = WAIT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they never depend on inputs combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_read     <= 1'b0;
            r_addr_sr     <= '0;
            r_burst_sr    <= '0;
            r_beats       <= '0;
            r_beat_idx    <= '0;
            r_base        <= '0;
            r_bit_cnt     <= '0;
            r_wait_cnt    <= '0;
            r_delay       <= '0;
            r_wdata_sr    <= '0;
            r_tx_sr       <= '0;
            r_slave_ready <= 1'b1;
            r_slave_valid <= 1'b0;
            r_split_en    <= 1'b0;
        end else begin
            r_slave_ready <= (w_next == IDLE) || (w_next == ADDR) || (w_next == WDATA) || (w_next == RESUME);
            r_slave_valid <= (w_next == RDATA);
            r_split_en    <= (w_next == SPLIT);
            case (r_state)
                IDLE: begin
                    if (w_next == ADDR) begin
                        r_is_read  <= s_read_en;
                        r_addr_sr  <= w_addr_full;
                        r_burst_sr <= w_burst_full;
                        r_bit_cnt  <= CNT_W'(1);
                    end
                end
                ADDR: begin
                    if (w_in_fire) begin
                        r_addr_sr  <= w_addr_full;
                        r_burst_sr <= w_burst_full;
                        if (w_addr_last) begin
                            r_bit_cnt  <= '0;
                            r_base     <= w_addr_full[MA-1:0];
                            r_beats    <= (w_burst_full == '0) ? BURST_LEN'(1) : w_burst_full;
                            r_beat_idx <= '0;
                            r_delay    <= s_slave_delay;
                            r_wait_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                WDATA: begin
                    if (w_in_fire) begin
                        r_wdata_sr <= w_wdata_full;
                        if (w_data_last) begin
                            r_bit_cnt  <= '0;
                            r_wait_cnt <= '0;
                            if (r_delay == 6'd0 && !w_last_beat) r_beat_idx <= r_beat_idx + BURST_LEN'(1);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (w_wait_done) begin
                        r_wait_cnt <= '0;
                        if (!r_is_read && !w_last_beat) r_beat_idx <= r_beat_idx + BURST_LEN'(1);
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 6'd1;
                    end
                end
                RFETCH: begin
                    r_tx_sr   <= r_mem[w_beat_addr];
                    r_bit_cnt <= '0;
                end
                SPLIT: begin
                    if (w_split_done) begin
                        r_tx_sr    <= r_mem[w_beat_addr];
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 6'd1;
                    end
                end
                RDATA: begin
                    if (w_out_fire) begin
                        r_tx_sr <= r_tx_sr >> 1;
                        if (w_data_last) begin
                            r_bit_cnt  <= '0;
                            r_wait_cnt <= '0;
                            if (!w_last_beat) r_beat_idx <= r_beat_idx + BURST_LEN'(1);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so an aborted write leaves the old word intact.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_beat_addr] <= w_mem_wdata;
    end

endmodule

// File: tb/tb_split_slave_mem.sv
// Directed bench for split_slave_mem: serial write/read, burst wrap, split reads,
// backpressure, reset abort and illegal transaction types.
module tb_split_slave_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] s_slave_delay;
    logic       s_read_en, s_write_en;
    logic       s_master_valid, s_master_ready;
    logic       s_rx_address, s_rx_burst, s_rx_data;
    logic       s_slave_ready, s_slave_valid, s_tx_data, s_split_en;

    int checks   = 0;
    int failures = 0;

    split_slave_mem dut (
        .clk            (clk),
        .rst            (rst),
        .s_slave_delay  (s_slave_delay),
        .s_read_en      (s_read_en),
        .s_write_en     (s_write_en),
        .s_master_valid (s_master_valid),
        .s_master_ready (s_master_ready),
        .s_rx_address   (s_rx_address),
        .s_rx_burst     (s_rx_burst),
        .s_rx_data      (s_rx_data),
        .s_slave_ready  (s_slave_ready),
        .s_slave_valid  (s_slave_valid),
        .s_tx_data      (s_tx_data),
        .s_split_en     (s_split_en)
    );

    always #5 clk = ~clk;

    // One inbound bit; waits (bounded) until the slave is ready at an edge.
    task automatic push_bit(input logic a, input logic b, input logic d);
        bit done = 1'b0;
        s_rx_address   = a;
        s_rx_burst     = b;
        s_rx_data      = d;
        s_master_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            if (s_slave_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        s_master_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("[TB] FAIL push_timeout actual=no_ready required=ready");
        end
    endtask

    task automatic pop_bit(output logic bit_o);
        bit done = 1'b0;
        bit_o = 1'b0;
        s_master_ready = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            if (s_slave_valid) begin
                bit_o = s_tx_data;
                done  = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_master_ready = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("[TB] FAIL pop_timeout actual=no_valid required=valid");
        end
    endtask

    task automatic send_header(input logic rd, input logic [11:0] addr, input logic [11:0] burst);
        s_read_en  = rd;
        s_write_en = !rd;
        for (int i = 0; i < 12; i++) push_bit(addr[i], burst[i], 1'b0);
        s_read_en  = 1'b0;
        s_write_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) push_bit(1'b0, 1'b0, b[i]);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic bt;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            pop_bit(bt);
            b[i] = bt;
        end
    endtask

    task automatic test_reset();
        logic [3:0] outs;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        outs = {s_slave_ready, s_slave_valid, s_tx_data, s_split_en};
        checks++;
        if (outs !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL reset_outputs actual=%b required=1000", outs);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_slave_ready !== 1'b1 || s_slave_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_idle actual=%b%b required=10", s_slave_ready, s_slave_valid);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] got;
        logic [7:0] bits;
        logic bt;
        s_slave_delay = 6'd0;
        send_header(1'b0, 12'h010, 12'd1);
        send_byte(8'hA5);
        send_header(1'b1, 12'h010, 12'd1);
        checks++;
        if (s_slave_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_early actual=%b required=0", s_slave_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (s_slave_valid !== 1'b1 || s_tx_data !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_one_cycle actual=%b%b required=11", s_slave_valid, s_tx_data);
        end
        for (int i = 0; i < 8; i++) begin
            pop_bit(bt);
            bits[7-i] = bt;
        end
        got = bits;
        checks++;
        if (got !== 8'b10100101) begin
            failures++;
            $display("[TB] FAIL serial_order actual=%b required=10100101", got);
        end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] got;
        s_slave_delay = 6'd2;
        send_header(1'b0, 12'hFFF, 12'd3);
        send_byte(8'h11);
        checks++;
        if (s_slave_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_wait_ready actual=%b required=0", s_slave_ready);
        end
        send_byte(8'h22);
        send_byte(8'h33);
        s_slave_delay = 6'd3;
        send_header(1'b1, 12'hFFF, 12'd3);
        recv_byte(got);
        checks++;
        if (got !== 8'h11) begin failures++; $display("[TB] FAIL wrap_beat0 actual=%h required=11", got); end
        recv_byte(got);
        checks++;
        if (got !== 8'h22) begin failures++; $display("[TB] FAIL wrap_beat1 actual=%h required=22", got); end
        recv_byte(got);
        checks++;
        if (got !== 8'h33) begin failures++; $display("[TB] FAIL wrap_beat2 actual=%h required=33", got); end
        s_slave_delay = 6'd0;
        send_header(1'b1, 12'h001, 12'd1);
        recv_byte(got);
        checks++;
        if (got !== 8'h33) begin failures++; $display("[TB] FAIL read_addr1 actual=%h required=33", got); end
    endtask

    task automatic test_burst_zero();
        logic [7:0] got;
        s_slave_delay = 6'd1;
        send_header(1'b0, 12'h101, 12'd1);
        send_byte(8'h77);
        send_header(1'b0, 12'h100, 12'd0);
        send_byte(8'h5A);
        send_header(1'b1, 12'h101, 12'd1);
        recv_byte(got);
        checks++;
        if (got !== 8'h77) begin failures++; $display("[TB] FAIL burst0_neighbor actual=%h required=77", got); end
        send_header(1'b1, 12'h100, 12'd0);
        recv_byte(got);
        checks++;
        if (got !== 8'h5A) begin failures++; $display("[TB] FAIL burst0_word actual=%h required=5a", got); end
    endtask

    task automatic test_threshold();
        logic [7:0] got;
        s_slave_delay = 6'd8;
        send_header(1'b1, 12'h010, 12'd1);
        @(posedge clk); #1;
        checks++;
        if (s_split_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_split_at_threshold actual=%b required=0", s_split_en);
        end
        recv_byte(got);
        checks++;
        if (got !== 8'hA5) begin failures++; $display("[TB] FAIL threshold_read actual=%h required=a5", got); end
    endtask

    task automatic test_split();
        logic [7:0] got;
        int cnt = 0;
        bit stray = 1'b0;
        s_slave_delay = 6'd20;
        send_header(1'b1, 12'hFFF, 12'd1);
        checks++;
        if (s_split_en !== 1'b1 || s_slave_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL split_entry actual=%b%b required=10", s_split_en, s_slave_ready);
        end
        while (s_split_en === 1'b1 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != 21) begin failures++; $display("[TB] FAIL split_cycles actual=%0d required=21", cnt); end
        for (int i = 0; i < 4; i++) begin
            if (s_slave_valid !== 1'b0 || s_slave_ready !== 1'b1) stray = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (stray) begin failures++; $display("[TB] FAIL resume_withheld actual=released required=withheld"); end
        s_master_valid = 1'b1;
        @(posedge clk); #1;
        s_master_valid = 1'b0;
        checks++;
        if (s_slave_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL resume_to_rdata actual=%b required=1", s_slave_valid);
        end
        recv_byte(got);
        checks++;
        if (got !== 8'h11) begin failures++; $display("[TB] FAIL split_data actual=%h required=11", got); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got;
        logic bt;
        logic held;
        bit moved = 1'b0;
        s_slave_delay = 6'd0;
        send_header(1'b1, 12'h010, 12'd1);
        got = '0;
        for (int i = 0; i < 3; i++) begin
            pop_bit(bt);
            got[i] = bt;
        end
        held = s_tx_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (s_tx_data !== held || s_slave_valid !== 1'b1) moved = 1'b1;
        end
        checks++;
        if (moved || held !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure_hold actual=%b required=0_stable", held);
        end
        for (int i = 3; i < 8; i++) begin
            pop_bit(bt);
            got[i] = bt;
        end
        checks++;
        if (got !== 8'hA5) begin failures++; $display("[TB] FAIL backpressure_data actual=%h required=a5", got); end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] got;
        logic [3:0] outs;
        s_slave_delay = 6'd0;
        send_header(1'b0, 12'h020, 12'd1);
        send_byte(8'h3C);
        send_header(1'b0, 12'h020, 12'd1);
        for (int i = 0; i < 4; i++) push_bit(1'b0, 1'b0, 1'b1);
        s_master_valid = 1'b1;
        rst = 1'b0;
        #1;
        outs = {s_slave_ready, s_slave_valid, s_tx_data, s_split_en};
        checks++;
        if (outs !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL reset_mid_write actual=%b required=1000", outs);
        end
        s_master_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send_header(1'b1, 12'h020, 12'd1);
        recv_byte(got);
        checks++;
        if (got !== 8'h3C) begin failures++; $display("[TB] FAIL aborted_write actual=%h required=3c", got); end
    endtask

    task automatic test_illegal();
        logic [7:0] got;
        logic [11:0] a;
        bit not_ready = 1'b0;
        a = 12'h010;
        s_slave_delay = 6'd0;
        for (int pass = 0; pass < 2; pass++) begin
            s_read_en  = (pass == 0);
            s_write_en = (pass == 0);
            for (int i = 0; i < 20; i++) begin
                if (s_slave_ready !== 1'b1) not_ready = 1'b1;
                push_bit((i < 12) ? a[i] : 1'b0, (i == 0), 1'b0);
            end
            s_read_en  = 1'b0;
            s_write_en = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        checks++;
        if (not_ready) begin failures++; $display("[TB] FAIL illegal_idle actual=left_idle required=idle"); end
        send_header(1'b1, 12'h010, 12'd1);
        recv_byte(got);
        checks++;
        if (got !== 8'hA5) begin failures++; $display("[TB] FAIL illegal_no_write actual=%h required=a5", got); end
    endtask

    initial begin
        rst            = 1'b1;
        s_slave_delay  = 6'd0;
        s_read_en      = 1'b0;
        s_write_en     = 1'b0;
        s_master_valid = 1'b0;
        s_master_ready = 1'b0;
        s_rx_address   = 1'b0;
        s_rx_burst     = 1'b0;
        s_rx_data      = 1'b0;
        test_reset();
        test_write_read();
        test_burst_wrap();
        test_burst_zero();
        test_threshold();
        test_split();
        test_backpressure();
        test_reset_mid_write();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
